// File: rtl/ram_sdp_pkg.sv
// ram_pkg: shared definitions for the simple dual-port RAM macro.
//   RDW_OLD / RDW_NEW : encodings of the same-address read-during-write policy.
//   clr_state_t       : states of the post-reset clear sequencer.
package ram_pkg;

    localparam int RDW_OLD = 0;   // same-address read returns pre-write contents
    localparam int RDW_NEW = 1;   // same-address read returns byte-merged new contents

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } clr_state_t;

endpackage

// File: rtl/ram_sdp_if.sv
// ram_sdp_if: request/response bundle of the simple dual-port RAM.
//   master : requester side (drives write and read requests).
//   slave  : RAM side (returns rd_data / rd_valid and init_busy).
// Signals:
//   wr_en, wr_addr, wr_be, wr_data : write request with per-byte enables.
//   rd_en, rd_addr                 : read request.
//   rd_data, rd_valid              : read response, rd_valid pulses once per read.
//   init_busy                      : high while the memory clear sequence runs.
interface ram_sdp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BWEN_WIDTH = DATA_WIDTH / 8;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BWEN_WIDTH-1:0] wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  init_busy;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );

endinterface

// File: rtl/ram_sdp_clear.sv
// ram_sdp_clear: post-reset clear sequencer for ram_sdp.
// After reset release it walks clr_ptr over every address once, requesting
// an all-zero write each cycle, then parks in READY for good.
// Ports:
//   i_clock      : clock, rising edge.
//   i_reset_n    : asynchronous active-low reset.
//   o_clr_we     : clear write strobe (one address per cycle).
//   o_clr_addr   : address being cleared.
//   o_init_busy  : high while user requests must be ignored.
module ram_sdp_clear
    import ram_pkg::*;
#(
    parameter int  DEPTH          = 16,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int ADDR_WIDTH     = $clog2(DEPTH)
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic                  o_init_busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    clr_state_t            r_state;
    clr_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic [ADDR_WIDTH-1:0] w_clr_ptr_next;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_RESET;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        o_clr_we       = 1'b0;
        o_init_busy    = 1'b0;
        case (r_state)
            ST_RESET: begin
                // Busy is already reported in reset so the requester never
                // sees a gap between reset and the start of the clear.
                o_init_busy  = (CLEAR_ON_RESET != 0);
                w_state_next = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
                o_init_busy = 1'b1;
                o_clr_we    = 1'b1;
                if (r_clr_ptr == LAST_ADDR) begin
                    w_state_next = ST_READY;
                end else begin
                    w_clr_ptr_next = r_clr_ptr + 1'b1;
                end
            end
            ST_READY: begin
                w_state_next = ST_READY;
            end
            default: begin
                w_state_next = ST_RESET;
            end
        endcase
    end

    assign o_clr_addr = r_clr_ptr;

endmodule

// File: rtl/ram_sdp.sv
// ram_sdp: simple dual-port synchronous RAM with byte enables.
// One write port and one independent read port on a single clock, a read
// pipeline of 1 or 2 stages, a selectable same-address read-during-write
// policy and an optional zeroing sequence after reset.
// Ports:
//   i_clock   : clock, rising edge.
//   i_reset_n : asynchronous active-low reset.
//   bus       : ram_sdp_if slave (write/read requests, read response, init_busy).
module ram_sdp
    import ram_pkg::*;
#(
    parameter int  DATA_WIDTH     = 32,
    parameter int  DEPTH          = 16,
    parameter int  READ_LATENCY   = 1,
    parameter int  RDW_MODE       = RDW_OLD,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int ADDR_WIDTH     = $clog2(DEPTH),
    localparam int BWEN_WIDTH     = DATA_WIDTH / 8
) (
    input  logic     i_clock,
    input  logic     i_reset_n,
    ram_sdp_if.slave bus
);

    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_init_busy;

    ram_sdp_clear #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr),
        .o_init_busy (w_init_busy)
    );

    assign bus.init_busy = w_init_busy;

    // ---------------------------------------------------------------
    // Request qualification. DEPTH need not be a power of two, so the
    // address field can name words that do not exist.
    // ---------------------------------------------------------------
    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_user_we;
    logic w_rd_acc;
    logic w_rdw_hit;

    assign w_wr_in_range = (32'(bus.wr_addr) < 32'(DEPTH));
    assign w_rd_in_range = (32'(bus.rd_addr) < 32'(DEPTH));
    assign w_user_we     = !w_init_busy && bus.wr_en && w_wr_in_range;
    assign w_rd_acc      = !w_init_busy && bus.rd_en;
    assign w_rdw_hit     = w_user_we && (bus.wr_addr == bus.rd_addr);

    // Clear writes own the port while busy; user writes are blocked then,
    // so the mux never has to arbitrate between two live writers.
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic [BWEN_WIDTH-1:0] w_mem_be;

    assign w_mem_we   = w_clr_we || w_user_we;
    assign w_mem_addr = w_clr_we ? w_clr_addr : bus.wr_addr;
    assign w_mem_data = w_clr_we ? '0         : bus.wr_data;
    assign w_mem_be   = w_clr_we ? '1         : bus.wr_be;

    // ---------------------------------------------------------------
    // Storage, one byte-wide array per lane so each byte enable maps to
    // an independent write strobe.
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rd_word;

    for (genvar gi = 0; gi < BWEN_WIDTH; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH];

        always_ff @(posedge i_clock) begin
            if (w_mem_we && w_mem_be[gi]) begin
                r_mem[w_mem_addr] <= w_mem_data[8*gi +: 8];
            end
        end

        // Out-of-range reads return zero; with RDW_NEW a colliding write
        // forwards only the lanes it actually enables.
        assign w_rd_word[8*gi +: 8] =
            !w_rd_in_range                                  ? 8'h00 :
            ((RDW_MODE == RDW_NEW) && w_rdw_hit && bus.wr_be[gi])
                                                            ? bus.wr_data[8*gi +: 8]
                                                            : r_mem[bus.rd_addr];
    end

    // ---------------------------------------------------------------
    // Read pipeline. Data registers only load on a valid so rd_data
    // holds the last returned word between reads.
    // ---------------------------------------------------------------
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_s2_valid;
        logic [DATA_WIDTH-1:0] r_s2_data;

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign bus.rd_valid = r_s2_valid;
        assign bus.rd_data  = r_s2_data;
    end else begin : g_lat1
        assign bus.rd_valid = r_s1_valid;
        assign bus.rd_data  = r_s1_data;
    end

endmodule

// File: tb/tb_ram_sdp.sv
// tb_ram_sdp: scoreboard bench for ram_sdp.
// Two instances share one stimulus stream:
//   inst 0: DEPTH=16, READ_LATENCY=1, RDW old-data.
//   inst 1: DEPTH=10, READ_LATENCY=2, RDW new-data (addresses 10..15 out of range).
// The driver keeps a plain word-array model per instance and pushes the
// expected read word and its due cycle; the monitor pops on rd_valid.
module tb_ram_sdp;
    import ram_pkg::*;

    localparam int NI = 2;
    localparam int DW = 32;
    localparam int AW = 4;

    function automatic int dep_of(input int k);
        return (k == 0) ? 16 : 10;
    endfunction
    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic int rdw_of(input int k);
        return (k == 0) ? RDW_OLD : RDW_NEW;
    endfunction

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] rd_data_a  [NI];
    logic          rd_valid_a [NI];
    logic          busy_a     [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int DEPTH_G = (gi == 0) ? 16 : 10;

        ram_sdp_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH_G)) bus ();

        assign bus.wr_en   = wr_en;
        assign bus.wr_addr = wr_addr;
        assign bus.wr_be   = wr_be;
        assign bus.wr_data = wr_data;
        assign bus.rd_en   = rd_en;
        assign bus.rd_addr = rd_addr;
        assign rd_data_a[gi]  = bus.rd_data;
        assign rd_valid_a[gi] = bus.rd_valid;
        assign busy_a[gi]     = bus.init_busy;

        ram_sdp #(
            .DATA_WIDTH     (DW),
            .DEPTH          (DEPTH_G),
            .READ_LATENCY   ((gi == 0) ? 1 : 2),
            .RDW_MODE       ((gi == 0) ? RDW_OLD : RDW_NEW),
            .CLEAR_ON_RESET (1)
        ) u_dut (
            .i_clock   (clk),
            .i_reset_n (rst_n),
            .bus       (bus)
        );
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q    [NI][$];
    logic [31:0] mem  [NI][16];
    logic [31:0] last [NI];
    int          rel  = 0;      // cycle count at the latest reset release
    logic        done = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic issue(input logic we, input logic [3:0] wa, input logic [3:0] be,
                         input logic [31:0] wd, input logic re, input logic [3:0] ra);
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        for (int k = 0; k < NI; k++) begin
            logic [31:0] old_w;
            logic [31:0] new_w;
            logic        wr_ok;
            exp_t        e;
            // Sampled on the next edge; busy covers DEPTH edges after the
            // first edge following release.
            if (!rst_n || (cyc < rel + dep_of(k) + 1)) continue;
            old_w = (int'(ra) < dep_of(k)) ? mem[k][ra] : 32'h0;
            wr_ok = we && (int'(wa) < dep_of(k));
            new_w = wr_ok ? mem[k][wa] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (wr_ok && be[b]) new_w[8*b +: 8] = wd[8*b +: 8];
            end
            if (re) begin
                e.data = old_w;
                if (rdw_of(k) == RDW_NEW && wr_ok && wa == ra) e.data = new_w;
                e.due = cyc + lat_of(k);
                q[k].push_back(e);
            end
            if (wr_ok) mem[k][wa] = new_w;
        end
    endtask

    task automatic idle();
        issue(1'b0, 4'd0, 4'd0, 32'h0, 1'b0, 4'd0);
    endtask

    task automatic rand_op();
        logic [3:0] wa;
        logic [3:0] ra;
        wa = 4'($urandom_range(0, 15));
        ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
        issue(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom,
              1'($urandom_range(0, 1)), ra);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) q[k].delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        // The clear sequence will zero everything before any request lands.
        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 16; a++) mem[k][a] = 32'h0;
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        for (int k = 0; k < NI; k++) last[k] = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < NI; k++) begin
                exp_t e;
                chk("init_busy", k, 32'(busy_a[k]), 32'(!rst_n || (cyc <= rel + dep_of(k))));
                if (!rst_n) begin
                    last[k] = 32'h0;
                    chk("reset_rd_valid", k, 32'(rd_valid_a[k]), 32'h0);
                    chk("reset_rd_data", k, rd_data_a[k], 32'h0);
                end else if (rd_valid_a[k]) begin
                    chk("valid_while_busy", k, 32'(busy_a[k]), 32'h0);
                    if (q[k].size() == 0) begin
                        chk("unexpected_rd_valid", k, 32'h1, 32'h0);
                    end else begin
                        e = q[k].pop_front();
                        $display("inst%0d read cycle %0d: data=%h expected=%h", k, cyc, rd_data_a[k], e.data);
                        chk("rd_data", k, rd_data_a[k], e.data);
                        chk("rd_latency", k, 32'(cyc), 32'(e.due));
                        last[k] = e.data;
                    end
                end else begin
                    chk("rd_data_hold", k, rd_data_a[k], last[k]);
                end
            end
            if (done) begin
                for (int k = 0; k < NI; k++) chk("reads_outstanding", k, 32'(q[k].size()), 32'h0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        release_reset();

        // Traffic during and after the clear (requests while busy must vanish).
        repeat (30) rand_op();

        // Byte-enable merge on address 3.
        issue(1'b1, 4'd3, 4'hF, 32'hAABBCCDD, 1'b0, 4'd0);
        issue(1'b1, 4'd3, 4'h5, 32'h11223344, 1'b0, 4'd0);
        issue(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd3);

        // Same-address read-during-write.
        issue(1'b1, 4'd5, 4'hF, 32'h00000000, 1'b0, 4'd0);
        issue(1'b1, 4'd5, 4'h3, 32'hFFFFFFFF, 1'b1, 4'd5);

        // Back-to-back reads 0..3.
        for (int a = 0; a < 4; a++) issue(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(a));

        // Address 12 is out of range only for the DEPTH=10 instance.
        issue(1'b1, 4'd12, 4'hF, 32'hDEADBEEF, 1'b0, 4'd0);
        issue(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd12);
        for (int a = 0; a < 16; a++) issue(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(a));

        // Random traffic leaves non-zero contents behind.
        repeat (400) rand_op();
        repeat (4) idle();

        // Reset, then abort the clear when clr_ptr reaches 7.
        assert_reset();
        repeat (2) idle();
        release_reset();
        repeat (7) idle();
        assert_reset();
        repeat (3) idle();
        release_reset();

        // Writes while busy must not land; then every address must read zero.
        for (int i = 0; i < 10; i++) issue(1'b1, 4'(i), 4'hF, $urandom | 32'h1, 1'b0, 4'd0);
        repeat (6) idle();
        for (int a = 0; a < 16; a++) issue(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(a));

        repeat (100) rand_op();
        repeat (6) idle();
        done = 1'b1;
    end

endmodule
